// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state encodings and grant ids for the memory bus arbiter
package mem_bus_arbiter_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_IC_RD = 3'd1;
  localparam logic [2:0] ST_DC_RD = 3'd2;
  localparam logic [2:0] ST_DC_WR = 3'd3;
  localparam logic [2:0] ST_DMA   = 3'd4;

  // Grant ids double as bit positions in the round-robin request vector.
  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_DC = 1'b1;

  function automatic logic is_read_state(input logic [2:0] st);
    return (st == ST_IC_RD) || (st == ST_DC_RD);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_rr2.sv
// rtl/mem_bus_arbiter_arb_rr2.sv - two-way round-robin pick between I-cache and D-cache
module arb_rr2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner,
  output logic       conflict
);

  // With both requesting, the cache that did not win last time goes next.
  always_comb begin
    valid    = |req;
    conflict = &req;
    if (conflict) begin
      winner = (last_grant == GNT_IC) ? GNT_DC : GNT_IC;
    end else begin
      winner = req[1] ? GNT_DC : GNT_IC;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares the block memory port between I-cache, D-cache and DMA
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int READ_SIZE = 4 * WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ic_readM,
  inout  wire  [READ_SIZE-1:0] ic_dataM,
  output logic                 ic_input_readyM,
  input  logic                 dc_readM,
  input  logic                 dc_writeM,
  inout  wire  [READ_SIZE-1:0] dc_dataM,
  output logic                 dc_input_readyM,
  output logic                 dc_doneM,
  input  logic                 dma_br,
  output logic                 bus_granted,
  output logic                 readM,
  output logic                 writeM,
  inout  wire  [READ_SIZE-1:0] dataM,
  input  logic                 input_readyM,
  input  logic                 doneM,
  output logic [WORD_SIZE-1:0] num_ic_grant,
  output logic [WORD_SIZE-1:0] num_dc_grant,
  output logic [WORD_SIZE-1:0] num_conflict
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       last_grant;
  logic       grant_ic;
  logic       grant_dc;
  logic       count_conflict;
  logic       rr_valid;
  logic       rr_winner;
  logic       rr_conflict;

  // A pending write still counts as a D-cache request so a concurrent I-cache
  // read registers as a conflict even though the write takes the bus.
  arb_rr2 u_rr (
    .req        ({dc_readM | dc_writeM, ic_readM}),
    .last_grant (last_grant),
    .valid      (rr_valid),
    .winner     (rr_winner),
    .conflict   (rr_conflict)
  );

  // Next-state and grant decision; transactions only ever start from IDLE.
  always_comb begin
    state_nxt      = state;
    grant_ic       = 1'b0;
    grant_dc       = 1'b0;
    count_conflict = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dma_br) begin
          state_nxt = ST_DMA;
        end else begin
          count_conflict = rr_conflict;
          if (dc_writeM) begin
            state_nxt = ST_DC_WR;
            grant_dc  = 1'b1;
          end else if (rr_valid) begin
            if (rr_winner == GNT_DC) begin
              state_nxt = ST_DC_RD;
              grant_dc  = 1'b1;
            end else begin
              state_nxt = ST_IC_RD;
              grant_ic  = 1'b1;
            end
          end
        end
      end
      ST_IC_RD, ST_DC_RD: begin
        if (input_readyM) state_nxt = ST_IDLE;
      end
      ST_DC_WR: begin
        if (doneM) state_nxt = ST_IDLE;
      end
      ST_DMA: begin
        if (!dma_br) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, round-robin history and statistics counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      last_grant   <= GNT_IC;
      num_ic_grant <= '0;
      num_dc_grant <= '0;
      num_conflict <= '0;
    end else begin
      state <= state_nxt;
      if (grant_ic) begin
        last_grant   <= GNT_IC;
        num_ic_grant <= num_ic_grant + WORD_SIZE'(1);
      end
      if (grant_dc) begin
        last_grant   <= GNT_DC;
        num_dc_grant <= num_dc_grant + WORD_SIZE'(1);
      end
      if (count_conflict) begin
        num_conflict <= num_conflict + WORD_SIZE'(1);
      end
    end
  end

  // Request/strobe steering follows the registered state only, so an async
  // reset drops readM/writeM in the same cycle.
  always_comb begin
    readM           = is_read_state(state) && !input_readyM;
    writeM          = (state == ST_DC_WR) && !doneM;
    ic_input_readyM = (state == ST_IC_RD) && input_readyM;
    dc_input_readyM = (state == ST_DC_RD) && input_readyM;
    dc_doneM        = (state == ST_DC_WR) && doneM;
    bus_granted     = (state == ST_DMA);
  end

  // Block buses are driven only in the one state that owns each direction.
  assign dataM    = (state == ST_DC_WR) ? dc_dataM : {READ_SIZE{1'bz}};
  assign ic_dataM = (state == ST_IC_RD) ? dataM    : {READ_SIZE{1'bz}};
  assign dc_dataM = (state == ST_DC_RD) ? dataM    : {READ_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for the memory bus arbiter
module tb_mem_bus_arbiter;

  localparam int WS = 16;
  localparam int RS = 64;
  localparam logic [1:0] K_IC = 2'd0;
  localparam logic [1:0] K_DC = 2'd1;
  localparam logic [1:0] K_WR = 2'd2;
  localparam logic [RS-1:0] WVAL = 64'h1111_2222_3333_4444;

  typedef struct packed {
    logic [1:0]    kind;
    logic [RS-1:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic reset_n;
  logic ic_readM, dc_readM, dc_writeM, dma_br;
  logic input_readyM, doneM;
  logic ic_input_readyM, dc_input_readyM, dc_doneM, bus_granted, readM, writeM;
  logic [WS-1:0] num_ic_grant, num_dc_grant, num_conflict;
  wire  [RS-1:0] ic_dataM, dc_dataM, dataM;

  logic          mdl_en, pm_en, pd_en, pi_en;
  logic [RS-1:0] mdl_val, pm_val, pd_val, pi_val;

  assign dataM    = mdl_en ? mdl_val : (pm_en ? pm_val : {RS{1'bz}});
  assign dc_dataM = pd_en ? pd_val : {RS{1'bz}};
  assign ic_dataM = pi_en ? pi_val : {RS{1'bz}};

  sb_t           sb_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            mem_lat  = 3;
  int            mem_cnt  = 0;
  int            rd_seq   = 0;
  int            exp_seq  = 0;
  int            done_pulses = 0;
  logic [RS-1:0] mem_wr_seen = '0;

  mem_bus_arbiter #(.WORD_SIZE(WS), .READ_SIZE(RS)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ic_readM        (ic_readM),
    .ic_dataM        (ic_dataM),
    .ic_input_readyM (ic_input_readyM),
    .dc_readM        (dc_readM),
    .dc_writeM       (dc_writeM),
    .dc_dataM        (dc_dataM),
    .dc_input_readyM (dc_input_readyM),
    .dc_doneM        (dc_doneM),
    .dma_br          (dma_br),
    .bus_granted     (bus_granted),
    .readM           (readM),
    .writeM          (writeM),
    .dataM           (dataM),
    .input_readyM    (input_readyM),
    .doneM           (doneM),
    .num_ic_grant    (num_ic_grant),
    .num_dc_grant    (num_dc_grant),
    .num_conflict    (num_conflict)
  );

  always #5 clk = ~clk;

  function automatic logic [RS-1:0] mem_word(input int n);
    return {32'hC0DE_5EED, 32'(n)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic sb_pop(input string who, input logic [1:0] kind, input logic [RS-1:0] data);
    sb_t e;
    check({who, "_expected"}, 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({who, "_kind"}, 64'(kind), 64'(e.kind));
      check({who, "_data"}, data, e.data);
    end
  endtask

  task automatic push_rd(input logic [1:0] kind);
    sb_q.push_back('{kind: kind, data: mem_word(exp_seq)});
    exp_seq++;
  endtask

  task automatic wait_sb(input string tag, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 64'(sb_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Memory: answers a read or write after mem_lat cycles of readM/writeM.
  initial begin
    mdl_en = 1'b0; mdl_val = '0; input_readyM = 1'b0; doneM = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        input_readyM = 1'b0; doneM = 1'b0; mdl_en = 1'b0; mem_cnt = 0;
      end else if (input_readyM || doneM) begin
        input_readyM = 1'b0; doneM = 1'b0; mdl_en = 1'b0; mem_cnt = 0;
      end else if (readM || writeM) begin
        if (mem_cnt == mem_lat) begin
          mem_cnt = 0;
          if (readM) begin
            input_readyM = 1'b1; mdl_en = 1'b1; mdl_val = mem_word(rd_seq); rd_seq++;
          end else begin
            doneM = 1'b1; mem_wr_seen = dataM;
          end
        end else begin
          mem_cnt++;
        end
      end
    end
  end

  // Completion monitor acting as both caches: compare against scoreboard, drop request.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (ic_input_readyM) begin sb_pop("ic", K_IC, ic_dataM); ic_readM = 1'b0; end
        if (dc_input_readyM) begin sb_pop("dc", K_DC, dc_dataM); dc_readM = 1'b0; end
        if (dc_doneM) begin
          sb_pop("wr", K_WR, dataM);
          dc_writeM = 1'b0; pd_en = 1'b0; done_pulses++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; ic_readM = 1'b0; dc_readM = 1'b0; dc_writeM = 1'b0; dma_br = 1'b0;
    pm_en = 1'b0; pd_en = 1'b0; pi_en = 1'b0;
    pm_val = '0; pd_val = '0; pi_val = '0;
    repeat (3) @(negedge clk);

    // Reset state, including released buses.
    check("rst_readM", 64'(readM), 64'd0);
    check("rst_writeM", 64'(writeM), 64'd0);
    check("rst_bus_granted", 64'(bus_granted), 64'd0);
    check("rst_strobes", 64'({ic_input_readyM, dc_input_readyM, dc_doneM}), 64'd0);
    check("rst_counters", 64'({num_ic_grant, num_dc_grant, num_conflict}), 64'd0);
    pm_en = 1'b1; pm_val = 64'hAAAA_5555_AAAA_5555;
    pd_en = 1'b1; pd_val = 64'hBBBB_0000_BBBB_0000;
    pi_en = 1'b1; pi_val = 64'hCCCC_1234_CCCC_1234;
    #1;
    check("rst_dataM_free", dataM, 64'hAAAA_5555_AAAA_5555);
    check("rst_dc_dataM_free", dc_dataM, 64'hBBBB_0000_BBBB_0000);
    check("rst_ic_dataM_free", ic_dataM, 64'hCCCC_1234_CCCC_1234);
    pm_en = 1'b0; pd_en = 1'b0; pi_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: reset in the middle of an I-cache read.
    mem_lat = 3;
    ic_readM = 1'b1;
    @(negedge clk);
    check("t1_readM_up", 64'(readM), 64'd1);
    check("t1_ic_grant", 64'(num_ic_grant), 64'd1);
    #2;
    reset_n = 1'b0; ic_readM = 1'b0;
    #1;
    check("t1_readM_abort", 64'(readM), 64'd0);
    check("t1_ic_grant_clr", 64'(num_ic_grant), 64'd0);
    check("t1_idle", 64'({bus_granted, writeM, ic_input_readyM}), 64'd0);
    pi_en = 1'b1; pi_val = 64'h0F0F_0F0F_0F0F_0F0F;
    pm_en = 1'b1; pm_val = 64'h1357_9BDF_1357_9BDF;
    #1;
    check("t1_ic_dataM_free", ic_dataM, 64'h0F0F_0F0F_0F0F_0F0F);
    check("t1_dataM_free", dataM, 64'h1357_9BDF_1357_9BDF);
    pi_en = 1'b0; pm_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 2: lone I-cache read with memory latency 3.
    begin
      int rd_cnt = 0, ir_cnt = 0, dcir_cnt = 0;
      mem_lat = 3;
      push_rd(K_IC);
      ic_readM = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        rd_cnt += int'(readM);
        ir_cnt += int'(ic_input_readyM);
        dcir_cnt += int'(dc_input_readyM);
      end
      check("t2_readM_cycles", 64'(rd_cnt), 64'd3);
      check("t2_ic_ready_pulses", 64'(ir_cnt), 64'd1);
      check("t2_dc_ready_pulses", 64'(dcir_cnt), 64'd0);
      check("t2_ic_grant", 64'(num_ic_grant), 64'd1);
      wait_sb("t2", 20);
    end

    // 3: both caches read together right after reset: D-cache first.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mem_lat = 2;
    push_rd(K_DC);
    push_rd(K_IC);
    ic_readM = 1'b1; dc_readM = 1'b1;
    wait_sb("t3", 60);
    check("t3_conflict", 64'(num_conflict), 64'd1);
    check("t3_dc_grant", 64'(num_dc_grant), 64'd1);
    check("t3_ic_grant", 64'(num_ic_grant), 64'd1);

    // 4: D-cache block write.
    begin
      int d0 = done_pulses, ic_seen = 0, wr_chk = 0;
      mem_lat = 3;
      sb_q.push_back('{kind: K_WR, data: WVAL});
      pd_en = 1'b1; pd_val = WVAL; dc_writeM = 1'b1;
      for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
        @(negedge clk);
        ic_seen += int'(ic_input_readyM);
        if (writeM && wr_chk == 0) begin
          check("t4_dataM_in_wr", dataM, WVAL);
          wr_chk = 1;
        end
      end
      repeat (3) begin
        @(negedge clk);
        ic_seen += int'(ic_input_readyM);
      end
      check("t4_wr_seen", 64'(wr_chk), 64'd1);
      check("t4_done_pulses", 64'(done_pulses - d0), 64'd1);
      check("t4_ic_ready_quiet", 64'(ic_seen), 64'd0);
      check("t4_mem_data", mem_wr_seen, WVAL);
      check("t4_dc_grant", 64'(num_dc_grant), 64'd2);
    end

    // 5: DMA request arriving during a D-cache read waits for it to finish.
    begin
      int ir_at = -1, bg_at = -1, early = 0;
      mem_lat = 4;
      push_rd(K_DC);
      dc_readM = 1'b1;
      repeat (2) @(negedge clk);
      dma_br = 1'b1;
      for (int i = 0; i < 40 && bg_at < 0; i++) begin
        @(negedge clk);
        if (dc_input_readyM) ir_at = i;
        if (bus_granted) begin
          if (ir_at < 0) early = 1;
          bg_at = i;
        end
      end
      check("t5_no_preempt", 64'(early), 64'd0);
      check("t5_bg_latency", 64'(bg_at - ir_at), 64'd2);
      check("t5_dma_no_rw", 64'({readM, writeM}), 64'd0);
      pm_en = 1'b1; pm_val = 64'hD3A0_D3A0_D3A0_D3A0;
      pd_en = 1'b1; pd_val = 64'h0DC0_0DC0_0DC0_0DC0;
      pi_en = 1'b1; pi_val = 64'h01C0_01C0_01C0_01C0;
      #1;
      check("t5_dma_owns_dataM", dataM, 64'hD3A0_D3A0_D3A0_D3A0);
      check("t5_dc_dataM_free", dc_dataM, 64'h0DC0_0DC0_0DC0_0DC0);
      check("t5_ic_dataM_free", ic_dataM, 64'h01C0_01C0_01C0_01C0);
      pm_en = 1'b0; pd_en = 1'b0; pi_en = 1'b0;
      dma_br = 1'b0;
      check("t5_bg_hold", 64'(bus_granted), 64'd1);
      @(negedge clk);
      check("t5_bg_release", 64'(bus_granted), 64'd0);
      check("t5_dc_grant", 64'(num_dc_grant), 64'd3);
      wait_sb("t5", 10);
    end

    // 6: I-cache flushes mid-read; a pending D-cache read is served next.
    begin
      int ir_i = -1, rd_after = -1, held_bad = 0;
      mem_lat = 5;
      push_rd(K_IC);
      ic_readM = 1'b1;
      @(negedge clk);
      push_rd(K_DC);
      dc_readM = 1'b1;
      @(negedge clk);
      ic_readM = 1'b0;
      for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
        @(negedge clk);
        if (ir_i < 0) begin
          if (ic_input_readyM) ir_i = i;
          else if (!readM) held_bad++;
        end else if (readM && rd_after < 0) begin
          rd_after = i;
        end
      end
      check("t6_readM_held", 64'(held_bad), 64'd0);
      check("t6_ic_completed", 64'(ir_i >= 0), 64'd1);
      check("t6_idle_gap", 64'(rd_after - ir_i), 64'd2);
      wait_sb("t6", 10);
      check("t6_ic_grant", 64'(num_ic_grant), 64'd2);
      check("t6_dc_grant", 64'(num_dc_grant), 64'd4);
      check("t6_conflict", 64'(num_conflict), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
